// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Groups the loader's two buses:
//     - the byte stream from the external source (valid/ready handshake)
//     - the instruction-memory write port driven by the loader
//   Ports (as seen from the loader, modport slave):
//     byte_valid  in   1   byte_data is valid this cycle
//     byte_data   in   8   stream byte
//     byte_ready  out  1   loader accepts a byte this cycle
//     wr_en       out  1   one-cycle instruction-memory write strobe
//     wr_addr     out  32  byte address of the write (word aligned)
//     wr_data     out  32  assembled instruction word
//   modport master is the opposite side: the byte source and memory observer.

interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time program loader. Receives a byte stream (header byte N, then
//   4*N little-endian data bytes), assembles 32-bit words and writes them to
//   instruction memory from byte address 0 upward. The core is held in reset
//   until the whole image has been written.
//   Ports:
//     clk          in   system clock, rising edge
//     rst          in   asynchronous, active-high reset
//     i_start      in   begin a load (honoured in IDLE, DONE, ERR only)
//     bus          slave side of imem_loader_if (byte stream + write port)
//     o_core_hold  out  high while the core must be held in reset
//     o_busy       out  high while a load is in progress (HDR/DATA/WRITE)
//     o_done       out  image loaded, core released
//     o_err        out  header rejected (N == 0 or N > NUM_INSTR)
//   NUM_INSTR must not exceed 255, since the header is a single byte.

module imem_loader #(
    parameter int NUM_INSTR = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    imem_loader_if.slave bus,
    output logic         o_core_hold,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err
);

    // Counter width large enough to hold the value NUM_INSTR itself.
    localparam int CW = $clog2(NUM_INSTR + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]    r_state;
    logic [CW-1:0] r_count_n;    // latched word count N
    logic [CW-1:0] r_word_cnt;   // words written so far
    logic [1:0]    r_byte_cnt;   // byte lane within the current word
    logic [23:0]   r_asm;        // lower three bytes of the word being built
    logic [31:0]   r_wr_addr;
    logic [31:0]   r_wr_data;

    logic          w_byte_ready;
    logic          w_hdr_bad;
    logic [CW-1:0] w_word_cnt_inc;

    // byte_ready is a pure state decode, so there is no path from
    // byte_valid back to byte_ready.
    assign w_byte_ready   = (r_state == S_HDR) || (r_state == S_DATA);
    assign w_hdr_bad      = (bus.byte_data == 8'd0) ||
                            ({24'd0, bus.byte_data} > 32'(NUM_INSTR));
    assign w_word_cnt_inc = r_word_cnt + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count_n  <= '0;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (i_start) begin
                        r_state <= S_HDR;
                    end
                end

                // byte_ready is high in HDR and DATA, so byte_valid alone
                // marks a transfer in these states.
                S_HDR: begin
                    if (bus.byte_valid) begin
                        if (w_hdr_bad) begin
                            r_state <= S_ERR;
                        end else begin
                            r_count_n  <= bus.byte_data[CW-1:0];
                            r_word_cnt <= '0;
                            r_byte_cnt <= '0;
                            r_state    <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (bus.byte_valid) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0: r_asm[7:0]   <= bus.byte_data;
                            2'd1: r_asm[15:8]  <= bus.byte_data;
                            2'd2: r_asm[23:16] <= bus.byte_data;
                            default: begin
                                // Final byte goes straight into the write
                                // register, so the word is presented in
                                // the WRITE cycle and then held.
                                r_wr_data <= {bus.byte_data, r_asm};
                                r_wr_addr <= 32'(r_word_cnt) << 2;
                                r_state   <= S_WRITE;
                            end
                        endcase
                    end
                end

                S_WRITE: begin
                    r_word_cnt <= w_word_cnt_inc;
                    r_state    <= (w_word_cnt_inc == r_count_n) ? S_DONE : S_DATA;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.byte_ready = w_byte_ready;
    assign bus.wr_en      = (r_state == S_WRITE);
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;

    assign o_core_hold = (r_state != S_DONE);
    assign o_busy      = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_WRITE);
    assign o_done      = (r_state == S_DONE);
    assign o_err       = (r_state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic core_hold, busy, done, err;

    imem_loader_if bus();

    imem_loader #(.NUM_INSTR(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .bus        (bus),
        .o_core_hold(core_hold),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int start_cyc;

    // Captured writes: {addr, data}
    logic [63:0] wq[$];

    // Every write strobe is recorded; byte_ready must be low in that cycle.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wq.push_back({bus.wr_addr, bus.wr_data});
            checks++;
            if (bus.byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_write: byte_ready=%b required 0 at addr %h", bus.byte_ready, bus.wr_addr);
            end
        end
    end

    typedef struct {
        string        name;
        logic [7:0]   hdr;
        int           nbytes;
        logic [95:0]  stream;     // bytes in stream order, first byte in [95:88]
        bit           gaps;
        bit           exp_err;
        int           exp_nw;
        logic [95:0]  exp_words;  // word j in [32*j +: 32]
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(bus.byte_ready), 32'd1);
        chk("start_err_clr", 32'(err), 32'd0);
        chk("start_hold", 32'(core_hold), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int w;
        if (gaps) begin
            bus.byte_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        w = 0;
        while (bus.byte_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: byte_ready stayed %b, required 1", bus.byte_ready);
        end
        tick();
    endtask

    task automatic wait_end(output int cycles);
        int w;
        w = 0;
        while (done !== 1'b1 && err !== 1'b1 && w < 400) begin
            tick();
            w++;
        end
        if (w >= 400) begin
            checks++;
            errors++;
            $display("FAIL end_timeout: done=%b err=%b after %0d cycles", done, err, w);
        end
        // Counted from the cycle in which start was presented.
        cycles = cyc - start_cyc + 1;
    endtask

    task automatic run_vec(input vec_t v);
        int cycles;
        int n;
        wq.delete();
        do_start();
        send_byte(v.hdr, v.gaps);
        for (int i = 0; i < v.nbytes; i++) send_byte(v.stream[95 - 8*i -: 8], v.gaps);
        bus.byte_valid = 1'b0;
        wait_end(cycles);
        chk({v.name, "_err"}, 32'(err), 32'(v.exp_err));
        chk({v.name, "_done"}, 32'(done), 32'(!v.exp_err));
        chk({v.name, "_hold"}, 32'(core_hold), 32'(v.exp_err));
        chk({v.name, "_busy"}, 32'(busy), 32'd0);
        chk({v.name, "_nwrites"}, 32'(wq.size()), 32'(v.exp_nw));
        n = (wq.size() < v.exp_nw) ? wq.size() : v.exp_nw;
        for (int j = 0; j < n; j++) begin
            chk({v.name, "_addr"}, wq[j][63:32], 32'(4*j));
            chk({v.name, "_data"}, wq[j][31:0], v.exp_words[32*j +: 32]);
        end
        if (!v.gaps && !v.exp_err) chk({v.name, "_cycles"}, 32'(cycles), 32'(2 + 5*v.exp_nw));
        $display("load %s: hdr=%h writes=%0d done=%b err=%b cycles=%0d", v.name, v.hdr, wq.size(), done, err, cycles);
    endtask

    initial begin
        int cycles;
        int nready;

        vt[0] = '{"two_words", 8'h02, 8, {64'h13050000_B3000000, 32'h0}, 1'b0, 1'b0, 2,
                  {32'h0, 32'h000000B3, 32'h00000513}};
        vt[1] = '{"hdr_zero", 8'h00, 0, 96'h0, 1'b0, 1'b1, 0, 96'h0};
        vt[2] = '{"hdr_33", 8'h21, 0, 96'h0, 1'b0, 1'b1, 0, 96'h0};
        vt[3] = '{"gappy", 8'h01, 4, {32'hAABBCCDD, 64'h0}, 1'b1, 1'b0, 1,
                  {64'h0, 32'hDDCCBBAA}};
        vt[4] = '{"three_words", 8'h03, 12, 96'h01020304_05060708_090A0B0C, 1'b0, 1'b0, 3,
                  {32'h0C0B0A09, 32'h08070605, 32'h04030201}};

        rst = 1'b1;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        repeat (2) tick();
        chk("rst_hold", 32'(core_hold), 32'd1);
        chk("rst_ready", 32'(bus.byte_ready), 32'd0);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 5; k++) run_vec(vt[k]);

        // Full-depth image: word j is {4j+3, 4j+2, 4j+1, 4j}.
        wq.delete();
        do_start();
        send_byte(8'h20, 1'b0);
        for (int j = 0; j < 32; j++)
            for (int b = 0; b < 4; b++) send_byte(8'(4*j + b), 1'b0);
        bus.byte_valid = 1'b0;
        wait_end(cycles);
        chk("full_done", 32'(done), 32'd1);
        chk("full_nwrites", 32'(wq.size()), 32'd32);
        chk("full_cycles", 32'(cycles), 32'd162);
        if (wq.size() == 32) begin
            chk("full_last_addr", wq[31][63:32], 32'h7C);
            for (int j = 0; j < 32; j++)
                chk("full_data", wq[j][31:0], {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)});
        end
        $display("load full32: writes=%0d done=%b cycles=%0d", wq.size(), done, cycles);

        // Reset in the middle of word 1 of a 3-word load.
        wq.delete();
        do_start();
        send_byte(8'h03, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        bus.byte_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_hold", 32'(core_hold), 32'd1);
        chk("mid_rst_ready", 32'(bus.byte_ready), 32'd0);
        chk("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("mid_rst_addr", bus.wr_addr, 32'h0);
        chk("mid_rst_data", bus.wr_data, 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_nwrites", 32'(wq.size()), 32'd1);
        if (wq.size() >= 1) chk("mid_rst_word0", wq[0][31:0], 32'h44332211);
        $display("reset mid-load: writes before reset=%0d", wq.size());
        tick();
        rst = 1'b0;
        tick();
        run_vec(vt[4]);

        // In DONE: no bytes accepted, then start re-holds the core.
        wq.delete();
        bus.byte_valid = 1'b1;
        bus.byte_data = 8'hEE;
        nready = 0;
        repeat (4) begin
            tick();
            if (bus.byte_ready !== 1'b0) nready++;
        end
        chk("done_ready", 32'(nready), 32'd0);
        chk("done_no_write", 32'(wq.size()), 32'd0);
        chk("done_stays", 32'(done), 32'd1);
        bus.byte_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_hold", 32'(core_hold), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        $display("done-state restart: core_hold=%b done=%b", core_hold, done);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
